// File: rtl/dec_lut_result_collector.sv
// Result collector behind the clocked LUT decoder. It captures one result per rising edge of found_i
// into a first-word-fall-through FIFO, and keeps wrapping accept/match counters plus a sticky overflow flag.
module dec_lut_result_collector #(
  parameter int                N_BITS   = 53,
  parameter int                DEPTH    = 4,
  parameter int                CNT_BITS = 16,
  parameter logic [N_BITS-1:0] EXP_VAL  = 53'h0F_FFFF_FFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    found_i,
  input  logic [N_BITS-1:0]       n_i,
  input  logic                    clr_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_BITS-1:0]       out_n,
  output logic                    out_match,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_BITS-1:0]     acc_cnt,
  output logic [CNT_BITS-1:0]     match_cnt,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic is_expected(input logic [N_BITS-1:0] v);
    return (v == EXP_VAL);
  endfunction

  logic [N_BITS-1:0]   mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic                found_q_r;
  logic [CNT_BITS-1:0] acc_r;
  logic [CNT_BITS-1:0] match_r;
  logic                ovf_r;

  logic                empty_s;
  logic                full_s;
  logic                cap_s;
  logic                pop_s;
  logic                push_s;
  logic [N_BITS-1:0]   head_s;
  logic [N_BITS-1:0]   out_n_s;
  logic                out_match_s;

  // Capture/handshake decode and the fall-through head view
  always_comb begin
    empty_s     = (level_r == LW'(0));
    full_s      = (level_r == LW'(DEPTH));
    cap_s       = found_i & ~found_q_r;
    pop_s       = ~empty_s & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    push_s      = cap_s & (~full_s | pop_s);
    head_s      = mem_r[rd_ptr_r];
    out_n_s     = '0;
    out_match_s = 1'b0;
    if (empty_s) begin
      out_n_s     = '0;
      out_match_s = 1'b0;
    end else begin
      out_n_s     = head_s;
      out_match_s = is_expected(head_s);
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= n_i;
    end
  end

  // Edge detector, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q_r <= 1'b0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      level_r   <= '0;
    end else begin
      found_q_r <= found_i;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Statistics; clear outranks counting and overflow marking in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      match_r <= '0;
      ovf_r   <= 1'b0;
    end else if (clr_i) begin
      acc_r   <= '0;
      match_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) begin
        acc_r <= acc_r + CNT_BITS'(1);
        if (is_expected(n_i)) begin
          match_r <= match_r + CNT_BITS'(1);
        end
      end
      if (cap_s & ~push_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign out_valid  = ~empty_s;
  assign out_n      = out_n_s;
  assign out_match  = out_match_s;
  assign fifo_level = level_r;
  assign acc_cnt    = acc_r;
  assign match_cnt  = match_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_dec_lut_result_collector.sv
// Self-checking bench for dec_lut_result_collector: directed scenarios plus randomized traffic against a queue model.
// A second instance with 8-bit counters exercises counter wrap within a short run.
module tb_dec_lut_result_collector;
  localparam int          DEPTH = 4;
  localparam logic [52:0] EXP   = 53'h0F_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        found_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        out_ready = 1'b0;
  logic [52:0] n_i = '0;

  logic        out_valid, out_match, overflow;
  logic [52:0] out_n;
  logic [2:0]  fifo_level;
  logic [15:0] acc_cnt, match_cnt;

  logic        w_valid, w_match, w_ovf;
  logic [52:0] w_n;
  logic [2:0]  w_level;
  logic [7:0]  w_acc, w_mcnt;

  int n_checks = 0;
  int n_fail = 0;

  dec_lut_result_collector dut (
    .clk(clk), .rst_n(rst_n), .found_i(found_i), .n_i(n_i), .clr_i(clr_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .out_match(out_match),
    .fifo_level(fifo_level), .acc_cnt(acc_cnt), .match_cnt(match_cnt), .overflow(overflow)
  );

  dec_lut_result_collector #(.CNT_BITS(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .found_i(found_i), .n_i(n_i), .clr_i(clr_i),
    .out_valid(w_valid), .out_ready(out_ready), .out_n(w_n), .out_match(w_match),
    .fifo_level(w_level), .acc_cnt(w_acc), .match_cnt(w_mcnt), .overflow(w_ovf)
  );

  initial forever #5 clk = ~clk;

  // Reference model: queue of buffered results plus plain integer statistics
  logic [52:0] q[$];
  bit          fprev;
  int unsigned acc, mc;
  bit          ov;

  task automatic model_reset();
    q.delete();
    fprev = 1'b0;
    acc = 0;
    mc = 0;
    ov = 1'b0;
  endtask

  task automatic model_step();
    bit cap, pop, push;
    cap  = found_i && !fprev;
    pop  = (q.size() != 0) && out_ready;
    push = cap && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(n_i);
    if (clr_i) begin
      acc = 0; mc = 0; ov = 1'b0;
    end else begin
      if (push) begin
        acc++;
        if (n_i == EXP) mc++;
      end
      if (cap && !push) ov = 1'b1;
    end
    fprev = found_i;
  endtask

  function automatic logic [52:0] exp_head();
    return (q.size() != 0) ? q[0] : 53'd0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [52:0] v);
    found_i = 1'b1; n_i = v; tick();
    found_i = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; found_i = 1'b0; clr_i = 1'b0; out_ready = 1'b0;
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (out_n !== 53'd0) begin n_fail++; $display("FAIL reset_out_n: got %0h want 0", out_n); end
    n_checks++; if (out_match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0b want 0", out_match); end
    n_checks++; if ({acc_cnt, match_cnt} !== 32'd0) begin n_fail++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", acc_cnt, match_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_capture();
    found_i = 1'b0; out_ready = 1'b0; tick();
    found_i = 1'b1; n_i = EXP; tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_checks++; if (out_n !== EXP) begin n_fail++; $display("FAIL single_out_n: got %0h want %0h", out_n, EXP); end
    n_checks++; if (out_match !== 1'b1) begin n_fail++; $display("FAIL single_match: got %0b want 1", out_match); end
    n_checks++; if (match_cnt !== 16'd1) begin n_fail++; $display("FAIL single_match_cnt: got %0d want 1", match_cnt); end
    tick(); tick();
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    n_checks++; if (acc_cnt !== 16'd1) begin n_fail++; $display("FAIL single_acc: got %0d want 1", acc_cnt); end
    found_i = 1'b0; tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_n !== 53'd0) begin n_fail++; $display("FAIL single_drain: got v=%0b n=%0h want v=0 n=0", out_valid, out_n); end
  endtask

  task automatic test_mismatch();
    pulse(53'd12345);
    n_checks++; if (out_n !== 53'd12345) begin n_fail++; $display("FAIL mis_out_n: got %0d want 12345", out_n); end
    n_checks++; if (out_match !== 1'b0) begin n_fail++; $display("FAIL mis_match: got %0b want 0", out_match); end
    n_checks++; if (acc_cnt !== 16'd2 || match_cnt !== 16'd1) begin n_fail++; $display("FAIL mis_cnts: got %0d/%0d want 2/1", acc_cnt, match_cnt); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) pulse(53'(v));
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %0b want 1", overflow); end
    n_checks++; if (acc_cnt !== 16'd6) begin n_fail++; $display("FAIL fill_acc: got %0d want 6", acc_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_n !== 53'(i + 1)) begin n_fail++; $display("FAIL fill_order[%0d]: got %0d want %0d", i, out_n, i + 1); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd0 || out_n !== 53'd0) begin n_fail++; $display("FAIL fill_empty: got lvl=%0d n=%0d want 0/0", fifo_level, out_n); end
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    n_checks++; if (overflow !== 1'b0 || acc_cnt !== 16'd0) begin n_fail++; $display("FAIL fill_clr: got ovf=%0b acc=%0d want 0/0", overflow, acc_cnt); end
  endtask

  task automatic test_full_pop_push();
    logic [52:0] exp_d [4];
    exp_d = '{53'd2, 53'd3, 53'd4, 53'd9};
    for (int v = 1; v <= 4; v++) pulse(53'(v));
    found_i = 1'b1; n_i = 53'd9; out_ready = 1'b1; tick();
    found_i = 1'b0; out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fpp_level: got %0d want 4", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %0b want 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_n !== exp_d[i]) begin n_fail++; $display("FAIL fpp_order[%0d]: got %0d want %0d", i, out_n, exp_d[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_clear_wrap();
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    out_ready = 1'b1;
    repeat (255) pulse(EXP);
    n_checks++; if (w_acc !== 8'd255 || w_mcnt !== 8'd255) begin n_fail++; $display("FAIL wrap_max: got %0d/%0d want 255/255", w_acc, w_mcnt); end
    pulse(EXP);
    n_checks++; if (w_acc !== 8'd0 || w_mcnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d/%0d want 0/0", w_acc, w_mcnt); end
    n_checks++; if (acc_cnt !== 16'd256) begin n_fail++; $display("FAIL wrap_wide: got %0d want 256", acc_cnt); end
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) pulse(53'(v));
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_ovf: got %0b want 1", overflow); end
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    n_checks++; if (acc_cnt !== 16'd0 || match_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr_zero: got %0d/%0d/%0b want 0/0/0", acc_cnt, match_cnt, overflow); end
    n_checks++; if (fifo_level !== 3'd4 || out_n !== 53'd1) begin n_fail++; $display("FAIL clr_keep: got lvl=%0d n=%0d want 4/1", fifo_level, out_n); end
    out_ready = 1'b1; repeat (4) tick(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    pulse(53'd7); pulse(53'd8); pulse(53'd9);
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL ar_pre_level: got %0d want 3", fifo_level); end
    #2;
    rst_n = 1'b0;
    found_i = 1'b1; n_i = 53'd77;
    #1;
    n_checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL ar_immediate: got v=%0b lvl=%0d want 0/0", out_valid, fifo_level); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_n !== 53'd77) begin n_fail++; $display("FAIL ar_capture: got v=%0b n=%0d want 1/77", out_valid, out_n); end
    n_checks++; if (acc_cnt !== 16'd1) begin n_fail++; $display("FAIL ar_acc: got %0d want 1", acc_cnt); end
    found_i = 1'b0; tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] r;
    int sel;
    for (int c = 0; c < 400; c++) begin
      r = {$urandom(), $urandom()};
      sel = $urandom_range(0, 3);
      found_i = ($urandom_range(0, 1) == 1);
      n_i = (sel == 0) ? EXP : (sel == 1) ? 53'($urandom_range(0, 15)) : r[52:0];
      out_ready = ($urandom_range(0, 2) == 0);
      clr_i = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, out_valid, q.size() != 0); end
      n_checks++; if (fifo_level !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, fifo_level, q.size()); end
      n_checks++; if (out_n !== exp_head()) begin n_fail++; $display("FAIL rnd_out_n c%0d: got %0h want %0h", c, out_n, exp_head()); end
      n_checks++; if (out_match !== ((q.size() != 0) && (q[0] == EXP))) begin n_fail++; $display("FAIL rnd_match c%0d: got %0b", c, out_match); end
      n_checks++; if (acc_cnt !== 16'(acc) || match_cnt !== 16'(mc)) begin n_fail++; $display("FAIL rnd_cnts c%0d: got %0d/%0d want %0d/%0d", c, acc_cnt, match_cnt, 16'(acc), 16'(mc)); end
      n_checks++; if (w_acc !== 8'(acc) || w_mcnt !== 8'(mc)) begin n_fail++; $display("FAIL rnd_wcnts c%0d: got %0d/%0d want %0d/%0d", c, w_acc, w_mcnt, 8'(acc), 8'(mc)); end
      n_checks++; if (overflow !== ov) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %0b want %0b", c, overflow, ov); end
    end
    found_i = 1'b0; out_ready = 1'b0; clr_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_mismatch();
    test_fill_overflow();
    test_full_pop_push();
    test_clear_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dec_lut_result_collector.md
Name: dec_lut_result_collector

Overview:
- Sits directly downstream of the clocked 52-bit LUT decoder. It consumes the decoder's level-type `found` flag and its 53-bit result `N`.
- Captures one result per rising edge of `found` and buffers it in a small first-word-fall-through FIFO. Results leave through a valid/ready handshake to the next stage.
- Also keeps a wrapping count of accepted results, a count of results matching an expected value, and a sticky overflow flag for results dropped while the FIFO was full.

Parameters:
- N_BITS, 53, width of decoder result and FIFO entries.
- DEPTH, 4, FIFO depth in entries; power of two, minimum 2.
- CNT_BITS, 16, width of the accepted-result and match counters.
- EXP_VAL, 53'h0F_FFFF_FFFF_FFFF (2^52-1), expected result compared against each captured entry.

Ports:
- clk  in  1  rising-edge clock, shared with the decoder.
- rst_n  in  1  asynchronous active-low reset.
- found_i  in  1  decoder found flag (level); sampled every cycle.
- n_i  in  N_BITS  decoder result; valid in any cycle where found_i=1.
- clr_i  in  1  synchronous clear of counters and overflow flag (FIFO contents untouched).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts head entry when out_valid=1.
- out_n  out  N_BITS  head entry of FIFO; 0 when empty.
- out_match  out  1  head entry equals EXP_VAL; 0 when empty.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries.
- acc_cnt  out  CNT_BITS  accepted (pushed) result count; wraps modulo 2^CNT_BITS.
- match_cnt  out  CNT_BITS  count of pushed results equal to EXP_VAL; wraps.
- overflow  out  1  sticky: set when a capture was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - found_q=0, FIFO pointers=0, fifo_level=0, out_valid=0, out_n=0, out_match=0.
  - acc_cnt=0, match_cnt=0, overflow=0.
  - Memory contents need no reset.
- Edge detect:
  - Register found_q <= found_i.
  - cap = found_i & ~found_q, so one capture per found assertion regardless of assertion length.
  - n_i is sampled in the cycle where cap=1.
- Pop: pop = out_valid & out_ready.
  - The head advances on that clock edge.
  - The next entry is visible on out_n in the following cycle.
  - Pop is ignored when empty.
- Push: push = cap & (fifo_level<DEPTH | pop).
  - If full and a pop occurs in the same cycle, the push is accepted and the level stays at DEPTH.
  - If full with no pop, the capture is dropped and overflow <= 1.
- Push into an empty FIFO: out_valid=1 and out_n=n_i are visible one cycle after the cap cycle. This is 1-cycle latency from the found edge.
- Level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Pointers: wrap modulo DEPTH.
- out_n and out_match are combinational from head memory and the empty flag, with no extra register stage.
- Counters:
  - acc_cnt +1 on every accepted push.
  - match_cnt +1 on an accepted push where n_i == EXP_VAL (full N_BITS compare).
  - Both wrap at 2^CNT_BITS-1 -> 0.
- clr_i = 1:
  - Next cycle acc_cnt=0, match_cnt=0, overflow=0.
  - A push in the same cycle as clr_i is still stored in the FIFO, but is not counted, and its drop (if any) does not set overflow (clear has priority).
- found_i held high across reset deassertion: found_q starts at 0, so the first cycle after reset captures (edge relative to reset state).
- Reset mid-operation: all buffered entries are discarded immediately; no partial handshake survives.
- out_ready may be high while out_valid=0; this has no effect.

Test Plan:
- Single capture:
  - Stimulus: n_i=2^52-1, found_i 0->1 held for 3 cycles, out_ready=0.
  - Response: out_valid=1 one cycle after the edge; fifo_level=1, acc_cnt=1, match_cnt=1, out_match=1.
- Mismatch:
  - Stimulus: n_i=53'd12345 pulsed.
  - Response: out_n=12345, out_match=0, acc_cnt increments, match_cnt unchanged.
- Fill and overflow:
  - Stimulus: 5 found pulses with values 1..5 and out_ready=0.
  - Response: fifo_level=4, overflow=1, acc_cnt=4. Draining gives 1,2,3,4 in order; level returns to 0 and out_n=0.
- Full with simultaneous pop and push:
  - Stimulus: FIFO full (1..4), out_ready=1 in the same cycle as a found edge with value 9.
  - Response: level stays 4, overflow stays 0, drain order 2,3,4,9.
- Clear and wrap:
  - Stimulus: force 65535 accepted pushes, then one more; then pulse clr_i.
  - Response: acc_cnt goes 65535->0 on wrap, and clr_i zeroes counters and overflow while FIFO contents remain.
- Async reset mid-stream:
  - Stimulus: assert rst_n=0 between clock edges with 3 entries queued.
  - Response: out_valid=0 and fifo_level=0 immediately without a clock; after release, the next found edge is captured normally.
